// File: rtl/matrix_mult_seq_ctrl.sv
// Sequenced 3x3 constant-matrix x vector multiply, C = A*B, built around one
// shared multiply-accumulate unit stepped over nine cycles per vector.
`timescale 1ns/1ps
module matrix_mult_seq_ctrl #(
  parameter int unsigned input_bit_width  = 4,
  parameter int unsigned output_bit_width = 16,
  parameter logic [output_bit_width-1:0] A00 = 16'd2755,
  parameter logic [output_bit_width-1:0] A01 = 16'd51466,
  parameter logic [output_bit_width-1:0] A02 = 16'd60744,
  parameter logic [output_bit_width-1:0] A10 = 16'd21889,
  parameter logic [output_bit_width-1:0] A11 = 16'd34092,
  parameter logic [output_bit_width-1:0] A12 = 16'd41511,
  parameter logic [output_bit_width-1:0] A20 = 16'd10840,
  parameter logic [output_bit_width-1:0] A21 = 16'd20687,
  parameter logic [output_bit_width-1:0] A22 = 16'd42472
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [input_bit_width-1:0]  B0,
  input  logic [input_bit_width-1:0]  B1,
  input  logic [input_bit_width-1:0]  B2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [output_bit_width-1:0] C0,
  output logic [output_bit_width-1:0] C1,
  output logic [output_bit_width-1:0] C2,
  output logic                        busy
);

  localparam int unsigned IW = input_bit_width;
  localparam int unsigned OW = output_bit_width;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [IW-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [OW-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;

  logic [OW-1:0] a_sel;
  logic [IW-1:0] b_sel;
  logic [OW-1:0] b_ext;
  logic [OW-1:0] prod;

  always_comb begin
    a_sel = '0;
    case ({row_q, col_q})
      4'b00_00: a_sel = A00;
      4'b00_01: a_sel = A01;
      4'b00_10: a_sel = A02;
      4'b01_00: a_sel = A10;
      4'b01_01: a_sel = A11;
      4'b01_10: a_sel = A12;
      4'b10_00: a_sel = A20;
      4'b10_01: a_sel = A21;
      4'b10_10: a_sel = A22;
      default:  a_sel = '0;
    endcase
  end

  always_comb begin
    b_sel = '0;
    case (col_q)
      2'd0:    b_sel = b0_q;
      2'd1:    b_sel = b1_q;
      2'd2:    b_sel = b2_q;
      default: b_sel = '0;
    endcase
  end

  // Multiply at accumulator width: the product is truncated mod 2^OW before
  // accumulation, which leaves the modular sum unchanged.
  assign b_ext = OW'(b_sel);
  assign prod  = a_sel * b_ext;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          b0_d    = B0;
          b1_d    = B1;
          b2_d    = B2;
          c0_d    = '0;
          c1_d    = '0;
          c2_d    = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        case (row_q)
          2'd0:    c0_d = c0_q + prod;
          2'd1:    c1_d = c1_q + prod;
          2'd2:    c2_d = c2_q + prod;
          default: ;
        endcase
        if (col_q == 2'd2) begin
          col_d = '0;
          if (row_q == 2'd2) begin
            row_d   = '0;
            state_d = DONE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign C0        = c0_q;
  assign C1        = c1_q;
  assign C2        = c2_q;

endmodule
